ex_branch_resolve: RTL and testbench
====================================

EX_BRANCH_RESOLVE -- requirements
Module: ex_branch_resolve

Interface
REQ-001 SHALL have parameter SQUASH_DEPTH, default 2, meaning the number of accepted wrong-path inputs dropped after a redirect (range 0..7).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning the ALU stage presents a valid instruction.
REQ-005 SHALL have port in_ready, output, 1, meaning this block accepts the input this cycle.
REQ-006 SHALL have port alu_result, input, 32, the ALU Output bus.
REQ-007 SHALL have ports carry_out, zero, overflow, negative, input, 1 each, the ALU flags; carry_out on subtract is borrow (1 = A below B unsigned).
REQ-008 SHALL have port br_type, input, 3: 0 none, 1 beq, 2 bne, 3 blt, 4 bge, 5 bltu, 6 bgeu, 7 jump.
REQ-009 SHALL have port br_target, input, 32, the redirect address.
REQ-010 SHALL have port pc_in, input, 32, the instruction PC.
REQ-011 SHALL have port flags_we, input, 1, meaning the instruction updates the flag register.
REQ-012 SHALL have port ovf_chk, input, 1, meaning the instruction is a trapping signed add/sub.
REQ-013 SHALL have ports out_valid, output, 1; out_ready, input, 1; out_result, output, 32; out_pc, output, 32: the downstream stream.
REQ-014 SHALL have port flags, output, 4, the registered {N,Z,C,V}.
REQ-015 SHALL have ports redirect, output, 1, and redirect_pc, output, 32.
REQ-016 SHALL have ports trap, output, 1, and trap_pc, output, 32.

Function
REQ-017 SHALL accept an input on a cycle where in_valid and in_ready are both high.
REQ-018 SHALL drive in_ready high when the 2-entry output FIFO is not full, or when the squash counter is nonzero.
REQ-019 SHALL drop an accepted input while the squash counter is nonzero: not enqueued, no flag update, no redirect or trap; the counter decrements by 1.
REQ-020 SHALL enqueue every non-squashed accepted input as {alu_result, pc_in}; out_valid rises the cycle after the accept into an empty FIFO (latency 1).
REQ-021 SHALL pop the FIFO head when out_valid and out_ready are both high; FIFO order is preserved.
REQ-022 SHALL accept a push and a pop in the same cycle when full, leaving the occupancy unchanged.
REQ-023 SHALL evaluate branch taken as follows: beq zero; bne !zero; blt negative^overflow; bge !(negative^overflow); bltu carry_out; bgeu !carry_out; jump 1; none 0.
REQ-024 SHALL pulse redirect for one cycle, with redirect_pc = br_target, the cycle after accepting a non-squashed taken branch, and SHALL load the squash counter with SQUASH_DEPTH on that accept.
REQ-025 SHALL still enqueue the branch instruction itself.
REQ-026 SHALL treat a taken branch accepted while the squash counter is nonzero as squashed, with no redirect.
REQ-027 SHALL load flags with {negative, zero, carry_out, overflow} on a non-squashed accept with flags_we high; otherwise flags hold.
REQ-028 SHALL clear redirect and trap to 0 on every cycle that is not a pulse cycle.

Reset
REQ-029 SHALL, while rst_n is low, immediately clear the FIFO, out_valid, flags (0000), redirect, redirect_pc, trap, trap_pc and the squash counter, regardless of state mid-operation.
REQ-030 SHALL hold in_ready low during reset and leave it low until the first clock edge after deassertion.

Configuration
REQ-031 SHALL, with macro EX_OVF_TRAP_EN defined, treat a non-squashed accept with ovf_chk and overflow both high as a trap: not enqueued, no flag update, trap pulses next cycle with trap_pc = pc_in, squash counter loaded with SQUASH_DEPTH.
REQ-032 SHALL, with EX_OVF_TRAP_EN undefined, tie trap and trap_pc to 0 and ignore ovf_chk.

Verification
REQ-033 SHALL cover: accept alu_result=0x0000_0005 with FIFO empty and out_ready=1 -> out_valid next cycle, out_result=5.
REQ-034 SHALL cover: beq with zero=1, br_target=0x40 -> redirect=1 for one cycle with redirect_pc=0x40; the next 2 accepts are dropped and the 3rd appears on the output.
REQ-035 SHALL cover: out_ready=0 with 3 back-to-back inputs -> in_ready low after 2 accepts; releasing out_ready drains them in order.
REQ-036 SHALL cover: bltu with carry_out=1 -> taken; bgeu with carry_out=1 -> not taken; flags_we=1 with N=1,C=1 -> flags=1010.
REQ-037 SHALL cover: with EX_OVF_TRAP_EN defined, ovf_chk=1, overflow=1, pc_in=0x100 -> trap pulse with trap_pc=0x100, nothing enqueued.
REQ-038 SHALL cover: rst_n asserted while the FIFO holds 2 entries and squash=1 -> out_valid=0, flags=0, counter=0 immediately.

Source files
------------

// File: rtl/ex_branch_resolve.sv
// ex_branch_resolve
// Execute-stage branch resolution with a 2-entry output FIFO, a registered
// {N,Z,C,V} flag register, a one-cycle redirect pulse and a wrong-path
// squash counter that drops the next SQUASH_DEPTH accepted inputs after a
// redirect.
//
// Optional feature: define EX_OVF_TRAP_EN to turn trapping signed add/sub
// overflow (ovf_chk & overflow) into a trap pulse. Without the macro, trap
// and trap_pc are tied low and ovf_chk is ignored.
module ex_branch_resolve #(
    parameter int unsigned SQUASH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_result,
    input  logic        carry_out,
    input  logic        zero,
    input  logic        overflow,
    input  logic        negative,
    input  logic [2:0]  br_type,
    input  logic [31:0] br_target,
    input  logic [31:0] pc_in,
    input  logic        flags_we,
    input  logic        ovf_chk,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_pc,
    output logic [3:0]  flags,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        trap,
    output logic [31:0] trap_pc
);

    localparam logic [2:0] SQUASH_LOAD = 3'(SQUASH_DEPTH);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLT  = 3'd3,
        BR_BGE  = 3'd4,
        BR_BLTU = 3'd5,
        BR_BGEU = 3'd6,
        BR_JUMP = 3'd7
    } br_type_e;

    // FIFO storage and pointers
    logic [31:0] res_q [2];
    logic [31:0] pc_q  [2];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q, count_d;

    // Control state
    logic        rdy_en_q;
    logic [2:0]  squash_q, squash_d;
    logic [3:0]  flags_q, flags_d;
    logic        redirect_q;
    logic [31:0] redirect_pc_q;

    // Decoded per-cycle events
    logic        fifo_full;
    logic        squash_active;
    logic        accept;
    logic        live;
    logic        is_trap;
    logic        trap_fire;
    logic        push;
    logic        pop;
    logic        br_taken;
    logic        redirect_fire;

    // Handshake and event decode; a full FIFO still accepts when the head
    // is leaving this cycle, and a squashing block always accepts since the
    // dropped input never needs a FIFO slot.
    always_comb begin
        fifo_full     = (count_q == 2'd2);
        squash_active = (squash_q != 3'd0);
        in_ready      = rdy_en_q & (~fifo_full | squash_active | out_ready);
        accept        = in_valid & in_ready;
        live          = accept & ~squash_active;
        out_valid     = (count_q != 2'd0);
        pop           = out_valid & out_ready;
        trap_fire     = live & is_trap;
        push          = live & ~is_trap;
        redirect_fire = push & br_taken;
    end

`ifdef EX_OVF_TRAP_EN
    logic        trap_q;
    logic [31:0] trap_pc_q;

    assign is_trap = ovf_chk & overflow;

    // Trap pulse register: one-cycle pulse carrying the faulting PC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q    <= 1'b0;
            trap_pc_q <= 32'd0;
        end else begin
            trap_q <= trap_fire;
            if (trap_fire) begin
                trap_pc_q <= pc_in;
            end
        end
    end

    assign trap    = trap_q;
    assign trap_pc = trap_pc_q;
`else
    logic unused_ovf_chk;

    assign unused_ovf_chk = ovf_chk;
    assign is_trap        = 1'b0;
    assign trap           = 1'b0;
    assign trap_pc        = 32'd0;
`endif

    // Branch condition evaluation from the ALU flags of the current input
    always_comb begin
        br_taken = 1'b0;
        case (br_type_e'(br_type))
            BR_NONE: br_taken = 1'b0;
            BR_BEQ:  br_taken = zero;
            BR_BNE:  br_taken = ~zero;
            BR_BLT:  br_taken = negative ^ overflow;
            BR_BGE:  br_taken = ~(negative ^ overflow);
            BR_BLTU: br_taken = carry_out;
            BR_BGEU: br_taken = ~carry_out;
            BR_JUMP: br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state for FIFO pointers, occupancy, squash counter and flags
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        squash_d = squash_q;
        flags_d  = flags_q;

        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (accept && squash_active) begin
            squash_d = squash_q - 3'd1;
        end else if (redirect_fire || trap_fire) begin
            squash_d = SQUASH_LOAD;
        end

        if (push && flags_we) begin
            flags_d = {negative, zero, carry_out, overflow};
        end
    end

    // FIFO entry storage, written at the write pointer on every push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q[0] <= 32'd0;
            res_q[1] <= 32'd0;
            pc_q[0]  <= 32'd0;
            pc_q[1]  <= 32'd0;
        end else if (push) begin
            res_q[wr_ptr_q] <= alu_result;
            pc_q[wr_ptr_q]  <= pc_in;
        end
    end

    // Control state registers; rdy_en_q keeps in_ready low until the first
    // clock edge after reset is released
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            squash_q <= 3'd0;
            flags_q  <= 4'd0;
            rdy_en_q <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            squash_q <= squash_d;
            flags_q  <= flags_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Redirect pulse register: high for exactly one cycle after a taken branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            redirect_q <= redirect_fire;
            if (redirect_fire) begin
                redirect_pc_q <= br_target;
            end
        end
    end

    assign out_result  = res_q[rd_ptr_q];
    assign out_pc      = pc_q[rd_ptr_q];
    assign flags       = flags_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Testbench for ex_branch_resolve: directed sequences, a branch/flag vector
// table and randomized traffic checked against a queue-based reference model.
module tb_ex_branch_resolve;

    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rstN;
    logic        inValid;
    logic        inReady;
    logic [31:0] aluResult;
    logic        carryOut;
    logic        zero;
    logic        overflow;
    logic        negative;
    logic [2:0]  brType;
    logic [31:0] brTarget;
    logic [31:0] pcIn;
    logic        flagsWe;
    logic        ovfChk;
    logic        outValid;
    logic        outReady;
    logic [31:0] outResult;
    logic [31:0] outPc;
    logic [3:0]  flagsOut;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        trap;
    logic [31:0] trapPc;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [63:0] mq[$];
    int          mSquash;
    logic [3:0]  mFlags;
    logic        mRedir;
    logic [31:0] mRedirPc;
    logic        mTrap;
    logic [31:0] mTrapPc;
    logic        mRdyEn;

    typedef struct {
        logic [2:0] bt;
        logic       n;
        logic       z;
        logic       c;
        logic       v;
        logic       we;
        logic       expRedir;
        logic [3:0] expFlags;
    } vec_t;

    vec_t vecs[$];

    ex_branch_resolve #(.SQUASH_DEPTH(SD)) dut (
        .clk        (clk),
        .rst_n      (rstN),
        .in_valid   (inValid),
        .in_ready   (inReady),
        .alu_result (aluResult),
        .carry_out  (carryOut),
        .zero       (zero),
        .overflow   (overflow),
        .negative   (negative),
        .br_type    (brType),
        .br_target  (brTarget),
        .pc_in      (pcIn),
        .flags_we   (flagsWe),
        .ovf_chk    (ovfChk),
        .out_valid  (outValid),
        .out_ready  (outReady),
        .out_result (outResult),
        .out_pc     (outPc),
        .flags      (flagsOut),
        .redirect   (redirect),
        .redirect_pc(redirectPc),
        .trap       (trap),
        .trap_pc    (trapPc)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic refTaken(input logic [2:0] bt);
        case (bt)
            3'd1:    return zero;
            3'd2:    return !zero;
            3'd3:    return negative != overflow;
            3'd4:    return negative == overflow;
            3'd5:    return carryOut;
            3'd6:    return !carryOut;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic modelReady();
        return mRdyEn && ((mq.size() < 2) || (mSquash > 0) || outReady);
    endfunction

    function automatic logic modelTrapCase();
`ifdef EX_OVF_TRAP_EN
        return ovfChk && overflow;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput();
        compare("in_ready", 32'(inReady), 32'(modelReady()));
        compare("out_valid", 32'(outValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            compare("out_result", outResult, mq[0][63:32]);
            compare("out_pc", outPc, mq[0][31:0]);
        end
        compare("flags", 32'(flagsOut), 32'(mFlags));
        compare("redirect", 32'(redirect), 32'(mRedir));
        if (mRedir) begin
            compare("redirect_pc", redirectPc, mRedirPc);
        end
        compare("trap", 32'(trap), 32'(mTrap));
        if (mTrap) begin
            compare("trap_pc", trapPc, mTrapPc);
        end
    endtask

    task automatic modelStep(input logic acc, input logic pop);
        mRedir = 1'b0;
        mTrap  = 1'b0;
        if (pop) begin
            void'(mq.pop_front());
        end
        if (acc) begin
            if (mSquash > 0) begin
                mSquash--;
            end else if (modelTrapCase()) begin
                mTrap   = 1'b1;
                mTrapPc = pcIn;
                mSquash = SD;
            end else begin
                mq.push_back({aluResult, pcIn});
                if (flagsWe) begin
                    mFlags = {negative, zero, carryOut, overflow};
                end
                if (refTaken(brType)) begin
                    mRedir   = 1'b1;
                    mRedirPc = brTarget;
                    mSquash  = SD;
                end
            end
        end
        mRdyEn = 1'b1;
    endtask

    // One clock cycle: check outputs at the falling edge, then advance model
    task automatic applyStimulus();
        logic acc;
        logic pop;
        @(negedge clk);
        checkOutput();
        acc = inValid && modelReady();
        pop = (mq.size() != 0) && outReady;
        @(posedge clk);
        modelStep(acc, pop);
        #1;
    endtask

    task automatic clearInputs();
        inValid   = 1'b0;
        aluResult = 32'd0;
        carryOut  = 1'b0;
        zero      = 1'b0;
        overflow  = 1'b0;
        negative  = 1'b0;
        brType    = 3'd0;
        brTarget  = 32'd0;
        pcIn      = 32'd0;
        flagsWe   = 1'b0;
        ovfChk    = 1'b0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        #1;
        mq.delete();
        mSquash = 0;
        mFlags  = 4'd0;
        mRedir  = 1'b0;
        mTrap   = 1'b0;
        mRdyEn  = 1'b0;
        compare("rst_out_valid", 32'(outValid), 32'd0);
        compare("rst_flags", 32'(flagsOut), 32'd0);
        compare("rst_in_ready", 32'(inReady), 32'd0);
        compare("rst_redirect", 32'(redirect), 32'd0);
        compare("rst_trap", 32'(trap), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
    endtask

    initial begin
        clearInputs();
        outReady = 1'b1;
        doReset();
        applyStimulus();

        // Single accept into an empty FIFO shows up one cycle later
        inValid   = 1'b1;
        aluResult = 32'h0000_0005;
        pcIn      = 32'h0000_0010;
        applyStimulus();
        compare("lat1_out_valid", 32'(outValid), 32'd1);
        compare("lat1_out_result", outResult, 32'h0000_0005);

        // Taken beq redirects and drops the next SD accepts
        brType   = 3'd1;
        zero     = 1'b1;
        brTarget = 32'h0000_0040;
        aluResult = 32'h0000_00B0;
        pcIn     = 32'h0000_0014;
        applyStimulus();
        compare("beq_redirect", 32'(redirect), 32'd1);
        compare("beq_redirect_pc", redirectPc, 32'h0000_0040);
        brType = 3'd0;
        zero   = 1'b0;
        aluResult = 32'h0000_00A1;
        applyStimulus();
        compare("beq_pulse_end", 32'(redirect), 32'd0);
        aluResult = 32'h0000_00A2;
        applyStimulus();
        aluResult = 32'h0000_00A3;
        applyStimulus();
        compare("squash_third", outResult, 32'h0000_00A3);

        // Backpressure: two accepts fill the FIFO, third waits, drain in order
        inValid = 1'b0;
        applyStimulus();
        applyStimulus();
        outReady  = 1'b0;
        inValid   = 1'b1;
        aluResult = 32'h0000_00B1;
        applyStimulus();
        aluResult = 32'h0000_00B2;
        applyStimulus();
        compare("full_in_ready", 32'(inReady), 32'd0);
        aluResult = 32'h0000_00B3;
        applyStimulus();
        outReady = 1'b1;
        applyStimulus();
        compare("drain_order", outResult, 32'h0000_00B2);
        inValid = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus();

        // Branch condition and flag vectors
        vecs.push_back('{3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0100});
        vecs.push_back('{3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1000});
        vecs.push_back('{3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
        vecs.push_back('{3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100});
        vecs.push_back('{3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1000});
        vecs.push_back('{3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001});
        vecs.push_back('{3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1001});
        vecs.push_back('{3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001});
        vecs.push_back('{3'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1010});
        vecs.push_back('{3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010});
        vecs.push_back('{3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000});
        vecs.push_back('{3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0110});
        vecs.push_back('{3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111});
        vecs.push_back('{3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111});
        outReady = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            inValid   = 1'b1;
            brType    = vecs[i].bt;
            negative  = vecs[i].n;
            zero      = vecs[i].z;
            carryOut  = vecs[i].c;
            overflow  = vecs[i].v;
            flagsWe   = vecs[i].we;
            aluResult = 32'h100 + 32'(i);
            pcIn      = 32'h1000 + 32'(i * 4);
            brTarget  = 32'h200 + 32'(i * 4);
            applyStimulus();
            compare("tbl_redirect", 32'(redirect), 32'(vecs[i].expRedir));
            compare("tbl_flags", 32'(flagsOut), 32'(vecs[i].expFlags));
            if (vecs[i].expRedir) begin
                brType   = 3'd0;
                flagsWe  = 1'b1;
                negative = ~negative;
                zero     = ~zero;
                for (int k = 0; k < SD; k++) applyStimulus();
            end
        end
        clearInputs();
        applyStimulus();
        applyStimulus();

`ifdef EX_OVF_TRAP_EN
        // Overflow trap: nothing enqueued, trap pulse with the faulting PC
        inValid  = 1'b1;
        ovfChk   = 1'b1;
        overflow = 1'b1;
        pcIn     = 32'h0000_0100;
        applyStimulus();
        compare("trap_pulse", 32'(trap), 32'd1);
        compare("trap_pc_val", trapPc, 32'h0000_0100);
        compare("trap_no_enq", 32'(outValid), 32'd0);
        clearInputs();
        for (int i = 0; i < SD + 1; i++) begin
            inValid = 1'b1;
            applyStimulus();
        end
        clearInputs();
        applyStimulus();
        applyStimulus();
`endif

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            inValid   = ($urandom_range(0, 3) != 0);
            aluResult = $urandom;
            pcIn      = $urandom;
            brTarget  = $urandom;
            brType    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            carryOut  = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            overflow  = 1'($urandom_range(0, 1));
            negative  = 1'($urandom_range(0, 1));
            flagsWe   = 1'($urandom_range(0, 1));
            ovfChk    = 1'($urandom_range(0, 1));
            outReady  = ($urandom_range(0, 3) != 0);
            applyStimulus();
        end

        // Reset mid-operation with a full FIFO and a live squash count
        clearInputs();
        outReady = 1'b1;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        outReady  = 1'b0;
        inValid   = 1'b1;
        flagsWe   = 1'b1;
        negative  = 1'b1;
        aluResult = 32'h0000_00C1;
        applyStimulus();
        flagsWe   = 1'b0;
        negative  = 1'b0;
        brType    = 3'd7;
        aluResult = 32'h0000_00C2;
        applyStimulus();
        brType    = 3'd0;
        aluResult = 32'h0000_00C3;
        applyStimulus();
        compare("pre_rst_valid", 32'(outValid), 32'd1);
        compare("pre_rst_flags", 32'(flagsOut), 32'b1000);
        clearInputs();
        doReset();
        applyStimulus();
        inValid   = 1'b1;
        outReady  = 1'b1;
        aluResult = 32'h0000_00D1;
        applyStimulus();
        compare("post_rst_enq", 32'(outValid), 32'd1);
        compare("post_rst_result", outResult, 32'h0000_00D1);
        inValid = 1'b0;
        applyStimulus();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
